// File: rtl/sp_req_arbiter_pkg.sv
// Shared datapath types for the scratchpad request path: op codes, the packed
// FIFO word and the packing helpers used when a request is accepted.
package datapath_pkg;

    localparam int SP_WORD_W = 38;
    localparam int SP_NMAT   = 16;

    typedef enum logic [1:0] {
        LOAD  = 2'b01,
        STORE = 2'b10,
        GEMM  = 2'b11
    } sp_op_t;

    typedef struct packed {
        sp_op_t      op;
        logic [3:0]  mat;
        logic [31:0] payload;
    } sp_word_t;

    function automatic sp_word_t pack_mls(input logic [1:0]  ls,
                                          input logic [3:0]  rd,
                                          input logic [31:0] rs,
                                          input logic [10:0] imm);
        sp_word_t w;
        w.op      = sp_op_t'(ls);
        w.mat     = rd;
        w.payload = rs + {{21{imm[10]}}, imm};
        return w;
    endfunction

    // GEMM words carry new_weight in the top bit of the mat field, sources in payload[15:4].
    function automatic sp_word_t pack_gemm(input logic       new_weight,
                                           input logic [3:0] rs1,
                                           input logic [3:0] rs2,
                                           input logic [3:0] rs3,
                                           input logic [3:0] rd);
        sp_word_t w;
        w.op      = GEMM;
        w.mat     = {new_weight, 3'b000};
        w.payload = {16'h0000, rs1, rs2, rs3, rd};
        return w;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        logic [31:0] r;
        if (en && (v != 32'hFFFF_FFFF)) begin
            r = v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/sp_req_arbiter_if.sv
// Request/FIFO bundle between the MLS/GEMM FUs, the arbiter and the scratchpad FIFO.
// SP_ARB_PERF_EN adds the two stall counter outputs.
interface sp_req_arbiter_if;

    logic                           mls_valid;
    logic [1:0]                     mls_ls;
    logic [3:0]                     mls_rd;
    logic [31:0]                    mls_rs;
    logic [10:0]                    mls_imm;
    logic                           mls_ready;
    logic                           gemm_valid;
    logic [3:0]                     gemm_rs1;
    logic [3:0]                     gemm_rs2;
    logic [3:0]                     gemm_rs3;
    logic [3:0]                     gemm_rd;
    logic                           gemm_new_weight;
    logic                           gemm_ready;
    logic                           flush;
    logic                           freeze;
    logic                           ld_done;
    logic [3:0]                     ld_done_rd;
    logic                           fifo_full;
    logic                           fifo_wen;
    logic [datapath_pkg::SP_WORD_W-1:0] fifo_wdata;
`ifdef SP_ARB_PERF_EN
    logic [31:0]                    perf_full_stall;
    logic [31:0]                    perf_hazard_stall;
`endif

    modport master (
        output mls_valid, mls_ls, mls_rd, mls_rs, mls_imm,
        output gemm_valid, gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd, gemm_new_weight,
        output flush, freeze, ld_done, ld_done_rd, fifo_full,
`ifdef SP_ARB_PERF_EN
        input  perf_full_stall, perf_hazard_stall,
`else
`endif
        input  mls_ready, gemm_ready, fifo_wen, fifo_wdata
    );

    modport slave (
        input  mls_valid, mls_ls, mls_rd, mls_rs, mls_imm,
        input  gemm_valid, gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd, gemm_new_weight,
        input  flush, freeze, ld_done, ld_done_rd, fifo_full,
`ifdef SP_ARB_PERF_EN
        output perf_full_stall, perf_hazard_stall,
`else
`endif
        output mls_ready, gemm_ready, fifo_wen, fifo_wdata
    );

endinterface

// File: rtl/sp_req_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; slot 0 = MLS, slot 1 = GEMM. The last-grant
// register resets to slot 1 so slot 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    logic last_q;
    logic last_d;
    logic [1:0] grant_s;

    // Grant selection: on a tie, the slot that did not win last time.
    always_comb begin
        grant_s = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = last_q ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
        if (grant_s[1]) begin
            last_d = 1'b1;
        end else if (grant_s[0]) begin
            last_d = 1'b0;
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign grant_o = grant_s;

endmodule

// File: rtl/sp_req_arbiter.sv
// Scratchpad request arbiter: one holding slot per requester, round-robin push
// into the scratchpad FIFO, pending-load scoreboard gating GEMM. Optional stall
// counters under SP_ARB_PERF_EN.
module sp_req_arbiter
    import datapath_pkg::*;
#(
    parameter int NMAT = SP_NMAT,
    parameter int WW   = SP_WORD_W
) (
    input  logic               CLK,
    input  logic               nRST,
    sp_req_arbiter_if.slave    bus
);

    logic            mls_hv_q, mls_hv_d;
    logic            gemm_hv_q, gemm_hv_d;
    sp_word_t        mls_word_q, mls_word_d;
    sp_word_t        gemm_word_q, gemm_word_d;
    logic [NMAT-1:0] sb_q, sb_d;
    logic            fifo_wen_q, fifo_wen_d;
    logic [WW-1:0]   fifo_wdata_q, fifo_wdata_d;

    logic            mls_acc_s, gemm_acc_s;
    logic            hazard_s, mls_elig_s, gemm_elig_s, arb_en_s;
    logic [1:0]      grant_s;

    assign bus.mls_ready  = !mls_hv_q  && !bus.freeze && !bus.flush;
    assign bus.gemm_ready = !gemm_hv_q && !bus.freeze && !bus.flush;
    assign mls_acc_s      = bus.mls_valid  && bus.mls_ready;
    assign gemm_acc_s     = bus.gemm_valid && bus.gemm_ready;

    assign hazard_s    = sb_q[gemm_word_q.payload[15:12]] |
                         sb_q[gemm_word_q.payload[11:8]]  |
                         sb_q[gemm_word_q.payload[7:4]];
    assign mls_elig_s  = mls_hv_q;
    assign gemm_elig_s = gemm_hv_q && !hazard_s;
    assign arb_en_s    = !bus.fifo_full && !bus.freeze && !bus.flush;

    rr_arb2 u_arb (
        .clk     (CLK),
        .rst_n   (nRST),
        .en_i    (arb_en_s),
        .req_i   ({gemm_elig_s, mls_elig_s}),
        .grant_o (grant_s)
    );

    // Next state for holders, push register and scoreboard.
    always_comb begin
        mls_hv_d     = mls_hv_q;
        gemm_hv_d    = gemm_hv_q;
        mls_word_d   = mls_word_q;
        gemm_word_d  = gemm_word_q;
        sb_d         = sb_q;
        fifo_wen_d   = 1'b0;
        fifo_wdata_d = fifo_wdata_q;

        if (bus.flush) begin
            mls_hv_d  = 1'b0;
            gemm_hv_d = 1'b0;
        end else if (grant_s[0]) begin
            mls_hv_d     = 1'b0;
            fifo_wen_d   = 1'b1;
            fifo_wdata_d = mls_word_q;
        end else if (grant_s[1]) begin
            gemm_hv_d    = 1'b0;
            fifo_wen_d   = 1'b1;
            fifo_wdata_d = gemm_word_q;
        end else begin
            fifo_wen_d = 1'b0;
        end

        if (mls_acc_s) begin
            mls_hv_d   = 1'b1;
            mls_word_d = pack_mls(bus.mls_ls, bus.mls_rd, bus.mls_rs, bus.mls_imm);
        end else begin
            mls_word_d = mls_word_q;
        end

        if (gemm_acc_s) begin
            gemm_hv_d   = 1'b1;
            gemm_word_d = pack_gemm(bus.gemm_new_weight, bus.gemm_rs1, bus.gemm_rs2,
                                    bus.gemm_rs3, bus.gemm_rd);
        end else begin
            gemm_word_d = gemm_word_q;
        end

        // Clear before set so a same-index collision leaves the bit set.
        if (bus.ld_done && !bus.freeze) begin
            sb_d[bus.ld_done_rd] = 1'b0;
        end else begin
            sb_d = sb_q;
        end
        if (grant_s[0] && (mls_word_q.op == LOAD)) begin
            sb_d[mls_word_q.mat] = 1'b1;
        end else begin
            sb_d = sb_d;
        end
    end

    // State and registered FIFO outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mls_hv_q     <= 1'b0;
            gemm_hv_q    <= 1'b0;
            mls_word_q   <= '0;
            gemm_word_q  <= '0;
            sb_q         <= '0;
            fifo_wen_q   <= 1'b0;
            fifo_wdata_q <= '0;
        end else begin
            mls_hv_q     <= mls_hv_d;
            gemm_hv_q    <= gemm_hv_d;
            mls_word_q   <= mls_word_d;
            gemm_word_q  <= gemm_word_d;
            sb_q         <= sb_d;
            fifo_wen_q   <= fifo_wen_d;
            fifo_wdata_q <= fifo_wdata_d;
        end
    end

    assign bus.fifo_wen   = fifo_wen_q;
    assign bus.fifo_wdata = fifo_wdata_q;

`ifdef SP_ARB_PERF_EN
    logic [31:0] perf_full_q;
    logic [31:0] perf_hazard_q;
    logic        full_stall_s;
    logic        hazard_stall_s;

    assign full_stall_s   = (mls_elig_s || gemm_elig_s) && bus.fifo_full && !bus.freeze;
    assign hazard_stall_s = gemm_hv_q && hazard_s && !bus.freeze;

    // Saturating stall counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_full_q   <= 32'd0;
            perf_hazard_q <= 32'd0;
        end else begin
            perf_full_q   <= sat_inc(perf_full_q, full_stall_s);
            perf_hazard_q <= sat_inc(perf_hazard_q, hazard_stall_s);
        end
    end

    assign bus.perf_full_stall   = perf_full_q;
    assign bus.perf_hazard_stall = perf_hazard_q;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: doc/sp_req_arbiter.md
# sp_req_arbiter

Scratchpad request arbiter for the execute stage. Accepts matrix load/store requests from the MLS FU and GEMM requests from the GEMM FU, packs each into the 38-bit scratchpad FIFO word and pushes it with a `wen`/`full` handshake. Arbitration between the two requesters is round-robin. A 16-entry pending-load scoreboard blocks any GEMM whose source matrix still has an outstanding load.

## Interface
Parameters:
- `NMAT`, 16: number of matrix registers; scoreboard depth.
- `WW`, 38: FIFO word width.

Ports:
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `mls_valid`  in  1  MLS request present.
- `mls_ls`  in  2  `2'b01` = load, `2'b10` = store; other codes are never issued.
- `mls_rd`  in  4  matrix register.
- `mls_rs`  in  32  base address.
- `mls_imm`  in  11  signed offset.
- `mls_ready`  out  1  MLS request accepted this cycle.
- `gemm_valid`  in  1  GEMM request present.
- `gemm_rs1`, `gemm_rs2`, `gemm_rs3`, `gemm_rd`  in  4 each  matrix registers.
- `gemm_new_weight`  in  1  reload weights.
- `gemm_ready`  out  1  GEMM request accepted.
- `flush`  in  1  drop held requests.
- `freeze`  in  1  stall all acceptance and pushes.
- `ld_done`  in  1  scratchpad load completed.
- `ld_done_rd`  in  4  matrix that completed.
- `fifo_full`  in  1  scratchpad FIFO full.
- `fifo_wen`  out  1  push.
- `fifo_wdata`  out  38  packed word.

## Operation
- Each requester has a one-entry holding register (`valid` + packed word).
  - `*_ready = !hold_valid & !freeze & !flush`.
  - Accept on `valid & ready`; pack at accept time.
- MLS packing: `{mls_ls, mls_rd, mls_rs + sext(mls_imm)}`. Addition is 32-bit and wraps modulo 2^32.
- GEMM packing: `{2'b11, gemm_new_weight, 3'b000, 16'd0, gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd}`.
- GEMM eligible: held, and `sb[rs1] | sb[rs2] | sb[rs3]` is 0. MLS eligible: held.
- Arbitration:
  - Push when `!fifo_full & !freeze` and at least one holder is eligible.
  - If both are eligible, grant goes to the requester not granted last; `last_grant` resets to GEMM, so MLS wins the first tie.
  - A granted push clears that holder.
- Scoreboard `sb[NMAT-1:0]`:
  - Set `sb[rd]` when an MLS load is pushed.
  - Clear `sb[ld_done_rd]` on `ld_done`.
  - Same-index set and clear in the same cycle: set wins.
  - `ld_done` for a clear bit: no effect.
- `flush`: clears both holders next edge; no push in that cycle; scoreboard untouched.
- `freeze`: holds every register; `fifo_wen` = 0.
- Flush and freeze together: flush wins for the holders.

## Timing
- Reset values:
  - `fifo_wen` = 0, `fifo_wdata` = 0.
  - `mls_ready` = 1 and `gemm_ready` = 1 once `nRST` deasserts.
  - `sb` = 0, holders empty, `last_grant` = GEMM.
- `fifo_wen`/`fifo_wdata` are registered. A request accepted at edge N can push at edge N+1, visible the cycle after. Minimum latency is 2 cycles from `valid` to `fifo_wen`.
- Throughput: one push per cycle; each requester sustains one request per 2 cycles (hold, then drain).
- A `fifo_full` asserted in a cycle suppresses that cycle's push. Data stays in the holder and nothing is lost.
- Reset mid-operation: holders, scoreboard and outputs clear immediately (asynchronous).

## Configuration
- `SP_ARB_PERF_EN` defined:
  - Adds 32-bit saturating counters `perf_full_stall` (eligible holder blocked by `fifo_full`) and `perf_hazard_stall` (GEMM held and blocked by scoreboard).
  - Both reset to 0 and are exposed as outputs.
- Undefined: counters and ports are absent; behaviour is otherwise identical.

## Structure
- Shared package `datapath_pkg`:
  - `sp_op_t` enum: LOAD = 2'b01, STORE = 2'b10, GEMM = 2'b11.
  - `sp_word_t` packed struct (op, mat, payload[31:0]).
  - `SP_WORD_W` = 38.
- Sub-module `rr_arb2`: 2-way round-robin arbiter (req[1:0] → grant[1:0], registered last-grant).

## Test plan
- Load: `mls_ls=01`, `rd=3`, `rs=0x1000`, `imm=-4` → `fifo_wdata` = {01, 3, 0x00000FFC}, `fifo_wen` 2 cycles after accept; `sb[3]` = 1.
- Hazard: load rd=3, then GEMM rs1=3 → GEMM held; `ld_done` with `rd=3` → GEMM pushes the next cycle as {11, 1000, 0x0000, 0x3xyz}.
- Tie: both eligible in back-to-back rounds → grants MLS, GEMM, MLS, GEMM.
- Full: `fifo_full=1` for 5 cycles with both held → `fifo_wen` = 0 throughout, both ready = 0; release → two pushes in consecutive cycles with no data loss.
- Flush: two held requests, assert `flush` → no push; holders empty; `sb` unchanged.
- Address wrap: `rs=0xFFFFFFFE`, `imm=+4` → address 0x00000002. Also check set/clear collision on one index → bit stays set.
